// File: rtl/program_loader_pkg.sv
// Shared types and sizing for the program loader: FSM encoding and stream framing constants.
package program_loader_pkg;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LEN_W          = BYTE_W * LEN_BYTES;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid pulses for one cycle per completed word.
module program_loader_byte_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_byte_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;

  assign last_byte_c = (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign word_valid  = word_valid_q;
  assign word        = word_q;

  // New bytes enter at the top so the first byte ends up in bits 7:0.
  always_comb begin
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (byte_valid) begin
      sr_d  = {byte_in, sr_q[WORD_W-1:BYTE_W]};
      cnt_d = cnt_q + BCNT_W'(1);
      if (last_byte_c) begin
        word_d       = {byte_in, sr_q[WORD_W-1:BYTE_W]};
        word_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      sr_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory; holds the CPU until verified.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [WORD_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] chk_q, chk_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hs;
  logic              asm_clear, asm_valid, asm_last;

  assign hs       = in_valid & in_ready_q;
  assign in_ready = in_ready_q;
  assign im_addr  = im_addr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

  program_loader_byte_assembler u_asm (
    .clk         (clock),
    .rst_n       (reset_n),
    .clear       (asm_clear),
    .byte_valid  (asm_valid),
    .byte_in     (in_byte),
    .last_byte_c (asm_last),
    .word_valid  (im_we),
    .word        (im_wdata)
  );

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    im_addr_d = im_addr_q;
    asm_clear = 1'b0;
    asm_valid = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          chk_d     = '0;
          idx_d     = '0;
          asm_clear = 1'b1;
          state_d   = S_LEN0;
        end
      end
      S_LEN0: begin
        if (hs) begin
          len_lo_d = in_byte;
          chk_d    = chk_q ^ in_byte;
          state_d  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (hs) begin
          len_d = {in_byte, len_lo_q};
          chk_d = chk_q ^ in_byte;
          if (len_d == '0)                       state_d = S_CHECK;
          else if (32'(len_d) > 32'(DEPTH))      state_d = S_ERROR;
          else                                   state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (hs) begin
          asm_valid = 1'b1;
          chk_d     = chk_q ^ in_byte;
          // Address is registered alongside the assembler's word_valid so both appear together.
          if (asm_last) begin
            im_addr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
            idx_d     = idx_q + LEN_W'(1);
            if (idx_q == len_q - LEN_W'(1)) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (hs) state_d = (in_byte == chk_q) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_CHECK);
    cpu_hold_d = (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERROR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      im_addr_q  <= ADDR_W'(BASE_ADDR);
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      im_addr_q  <= im_addr_d;
      in_ready_q <= in_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued by stimulus, checked by monitors.
module tb_program_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_ready0, im_we0, cpu_hold0, done0, error0;
  logic        in_ready1, im_we1, cpu_hold1, done1, error1;
  logic [7:0]  im_addr0, im_addr1;
  logic [31:0] im_wdata0, im_wdata1;

  int tests = 0;
  int fails = 0;
  wr_t q0[$];
  wr_t q1[$];
  logic [31:0] img_a [4];
  logic [31:0] img_b [4];

  always #5 clock = ~clock;

  program_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready0), .im_we(im_we0), .im_addr(im_addr0), .im_wdata(im_wdata0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0));

  program_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(254)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready1), .im_we(im_we1), .im_addr(im_addr1), .im_wdata(im_wdata1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1));

  // Write monitors: every im_we pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (im_we0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL dut0_write unexpected: addr=%0d data=%h expected none", im_addr0, im_wdata0);
      end else begin
        wr_t e;
        e = q0.pop_front();
        if (im_addr0 !== e.addr || im_wdata0 !== e.data) begin
          fails++;
          $display("FAIL dut0_write: addr=%0d data=%h expected addr=%0d data=%h",
                   im_addr0, im_wdata0, e.addr, e.data);
        end
      end
    end
    if (im_we1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL dut1_write unexpected: addr=%0d data=%h expected none", im_addr1, im_wdata1);
      end else begin
        wr_t e;
        e = q1.pop_front();
        if (im_addr1 !== e.addr || im_wdata1 !== e.data) begin
          fails++;
          $display("FAIL dut1_write: addr=%0d data=%h expected addr=%0d data=%h",
                   im_addr1, im_wdata1, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clock); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that accepted the byte.
  task automatic send_byte(input bit sel, input logic [7:0] b, input int gap);
    bit rdy;
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_valid = 1'b1;
    in_byte  = b;
    n = 0;
    forever begin
      @(negedge clock);
      rdy = sel ? in_ready1 : in_ready0;
      @(posedge clock); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: byte %h not accepted within 50 cycles", b);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_image(input bit sel, input int n, input logic [31:0] w [4],
                            input logic [7:0] corrupt, input int maxgap);
    logic [7:0] chk;
    logic [7:0] b;
    logic [7:0] base;
    wr_t e;
    base = sel ? 8'd254 : 8'd0;
    chk  = 8'h00;
    b = 8'(n);          chk ^= b; send_byte(sel, b, $urandom_range(0, maxgap));
    b = 8'(n >> 8);     chk ^= b; send_byte(sel, b, $urandom_range(0, maxgap));
    for (int k = 0; k < n; k++) begin
      e.addr = base + 8'(k);
      e.data = w[k];
      if (sel) q1.push_back(e); else q0.push_back(e);
      for (int j = 0; j < 4; j++) begin
        b = w[k][8*j +: 8];
        chk ^= b;
        send_byte(sel, b, $urandom_range(0, maxgap));
      end
    end
    send_byte(sel, chk ^ corrupt, $urandom_range(0, maxgap));
  endtask

  task automatic check_state0(input string name, input bit d, input bit er, input bit hold);
    check({name, "_done"},  32'(done0),     32'(d));
    check({name, "_error"}, 32'(error0),    32'(er));
    check({name, "_hold"},  32'(cpu_hold0), 32'(hold));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t e;
    img_a = '{32'h11223344, 32'hA5A5_0001, 32'h0, 32'h0};
    img_b = '{32'hDEADBEEF, 32'h0000_00FF, 32'h8000_0001, 32'h0};

    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", 32'(in_ready0), 32'd0);
    check("rst_im_we",    32'(im_we0),    32'd0);
    check("rst_im_addr0", 32'(im_addr0),  32'd0);
    check("rst_im_addr1", 32'(im_addr1),  32'd254);
    check("rst_im_wdata", im_wdata0,      32'd0);
    check_state0("rst", 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic two-word image, back-to-back bytes.
    pulse_start(1'b0);
    check("start_in_ready", 32'(in_ready0), 32'd1);
    send_image(1'b0, 2, img_a, 8'h00, 0);
    check_state0("basic", 1'b1, 1'b0, 1'b0);
    check("basic_in_ready", 32'(in_ready0), 32'd0);

    // Same image with random stalls.
    pulse_start(1'b0);
    check_state0("restart", 1'b0, 1'b0, 1'b1);
    send_image(1'b0, 2, img_a, 8'h00, 5);
    repeat (3) @(posedge clock);
    #1;
    check_state0("gaps", 1'b1, 1'b0, 1'b0);

    // Oversized length rejected right after LEN_HI.
    pulse_start(1'b0);
    send_byte(1'b0, 8'h01, 0);
    send_byte(1'b0, 8'h01, 0);
    check_state0("toolong", 1'b0, 1'b1, 1'b1);
    check("toolong_in_ready", 32'(in_ready0), 32'd0);
    repeat (5) @(posedge clock);
    #1;

    // Empty image, good then bad checksum.
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    check_state0("empty_ok", 1'b1, 1'b0, 1'b0);
    pulse_start(1'b0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h00, 0);
    send_byte(1'b0, 8'h5A, 0);
    check_state0("empty_bad", 1'b0, 1'b1, 1'b1);

    // Single word with corrupted checksum still writes, then a clean reload.
    pulse_start(1'b0);
    send_image(1'b0, 1, img_b, 8'h80, 1);
    check_state0("n1_bad", 1'b0, 1'b1, 1'b1);
    pulse_start(1'b0);
    send_image(1'b0, 3, img_b, 8'h00, 2);
    check_state0("n3_ok", 1'b1, 1'b0, 1'b0);

    // Async reset during the 3rd byte of word 1.
    pulse_start(1'b0);
    e.addr = 8'd0;
    e.data = img_a[0];
    q0.push_back(e);
    send_byte(1'b0, 8'h02, 0);
    send_byte(1'b0, 8'h00, 0);
    for (int j = 0; j < 4; j++) send_byte(1'b0, img_a[0][8*j +: 8], 0);
    send_byte(1'b0, img_a[1][7:0], 0);
    send_byte(1'b0, img_a[1][15:8], 0);
    in_valid = 1'b1;
    in_byte  = img_a[1][23:16];
    #2 reset_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready0), 32'd0);
    check("arst_im_we",    32'(im_we0),    32'd0);
    check("arst_im_addr",  32'(im_addr0),  32'd0);
    check("arst_im_wdata", im_wdata0,      32'd0);
    check_state0("arst", 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    pulse_start(1'b0);
    send_image(1'b0, 2, img_a, 8'h00, 1);
    check_state0("reload", 1'b1, 1'b0, 1'b0);

    // Address wrap on the BASE_ADDR=254 instance.
    pulse_start(1'b1);
    send_image(1'b1, 3, img_b, 8'h00, 0);
    check("wrap_done", 32'(done1),     32'd1);
    check("wrap_hold", 32'(cpu_hold1), 32'd0);
    check("wrap_err",  32'(error1),    32'd0);

    repeat (3) @(posedge clock);
    #1;
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
